// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Conditions the five Basys3 push-buttons before any consumer sees them.
//   Each channel has a 2-FF synchroniser, a debouncer, single-cycle
//   press/release pulses and long-press detection. Channels are independent.
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     When defined, a held long press re-pulses btn_press every
//     REPEAT_CYCLES edges, starting REPEAT_CYCLES edges after btn_long.
//
// Ports
//   clk            in   system clock (100 MHz)
//   rst_n          in   synchronous reset, active-low
//   btn_raw        in   asynchronous raw button pins, {D,U,R,L,C} = [4:0]
//   btn_level      out  debounced level, 1 = held
//   btn_press      out  1-cycle pulse on debounced rise (and auto-repeat)
//   btn_release    out  1-cycle pulse on debounced fall
//   btn_long       out  1-cycle pulse when a hold reaches LONG_CYCLES
//   btn_held_long  out  1 from the btn_long pulse until release
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int REPEAT_CYCLES   = 20000000,
    parameter int CNT_W           = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_held_long
);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} hold_state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`else
    // REPEAT_CYCLES only matters to the auto-repeat build.
    logic unused_repeat;
    assign unused_repeat = (REPEAT_CYCLES > 0);
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic             sync1;
        logic             sync2;
        logic [CNT_W-1:0] deb_cnt;
        logic [CNT_W-1:0] hold_cnt;
        hold_state_t      state;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             long_q;
        logic             held_q;
        logic             commit;
        logic             rise;
        logic             fall;
`ifdef BTN_AUTOREPEAT_EN
        logic [CNT_W-1:0] rep_cnt;
`endif

        // The debounced level flips on the edge where the synchronised input
        // has disagreed with it for DEBOUNCE_CYCLES consecutive samples; the
        // pulses and the hold FSM react to that same edge, so everything
        // downstream lines up with the btn_level change.
        always_comb begin
            commit = (sync2 != level_q) && (deb_cnt == DEB_LAST);
            rise   = commit && sync2;
            fall   = commit && !sync2;
        end

        // Synchroniser, debouncer, pulse registers and hold FSM. A fall on
        // the same edge as the long threshold takes priority, so btn_long
        // cannot fire for a press that is ending.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1     <= 1'b0;
                sync2     <= 1'b0;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                state     <= IDLE;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                held_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rep_cnt   <= '0;
`endif
            end else begin
                sync1 <= btn_raw[i];
                sync2 <= sync1;

                if (sync2 == level_q) begin
                    deb_cnt <= '0;
                end else if (commit) begin
                    level_q <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + CNT_ONE;
                end

                press_q   <= rise;
                release_q <= fall;
                long_q    <= 1'b0;

                case (state)
                    IDLE: begin
                        if (rise) begin
                            state    <= PRESSED;
                            hold_cnt <= '0;
                        end
                    end
                    PRESSED: begin
                        if (fall) begin
                            state <= IDLE;
                        end else if (hold_cnt == LONG_LAST) begin
                            state  <= LONG;
                            long_q <= 1'b1;
                            held_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rep_cnt <= '0;
`endif
                        end else begin
                            hold_cnt <= hold_cnt + CNT_ONE;
                        end
                    end
                    LONG: begin
                        if (fall) begin
                            state  <= IDLE;
                            held_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                            rep_cnt <= '0;
`endif
                        end
`ifdef BTN_AUTOREPEAT_EN
                        else if (rep_cnt == REP_LAST) begin
                            rep_cnt <= '0;
                            press_q <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + CNT_ONE;
                        end
`endif
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end

        assign btn_level[i]     = level_q;
        assign btn_press[i]     = press_q;
        assign btn_release[i]   = release_q;
        assign btn_long[i]      = long_q;
        assign btn_held_long[i] = held_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
//   Drives btn_conditioner with short timing parameters through directed
//   scenarios followed by a random phase, comparing every output on every
//   cycle against a window-based behavioural model of the button rules.
module tb_btn_conditioner;

    localparam int N_BTN = 5;
    localparam int DEB   = 4;
    localparam int LONGC = 20;
    localparam int REP   = 5;
    localparam int CNT_W = 27;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;
    logic [N_BTN-1:0] btn_held_long;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: synchronised sample history per channel, debounced level,
    // edge index of the latest press, and the expected outputs.
    logic [N_BTN-1:0] m_sync1 = '0;
    logic [N_BTN-1:0] m_sync2 = '0;
    logic [N_BTN-1:0] m_level = '0;
    bit               samp_q [N_BTN][$];
    int               press_t [N_BTN];
    int               t = 0;
    logic [N_BTN-1:0] e_level, e_press, e_release, e_long, e_held;

    btn_conditioner #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONGC),
        .REPEAT_CYCLES  (REP),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .btn_release  (btn_release),
        .btn_long     (btn_long),
        .btn_held_long(btn_held_long)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge. A level change needs the last DEB
    // synchronised samples to all disagree with the current level; long and
    // repeat events are derived from the age of the current press.
    task automatic modelEdge(input logic [N_BTN-1:0] raw, input logic rst);
        logic [N_BTN-1:0] d;
        bit               all_diff;
        int               age;
        t++;
        e_press   = '0;
        e_release = '0;
        e_long    = '0;
        e_held    = '0;
        if (!rst) begin
            m_sync1 = '0;
            m_sync2 = '0;
            m_level = '0;
            for (int c = 0; c < N_BTN; c++) samp_q[c].delete();
        end else begin
            d       = m_sync2;
            m_sync2 = m_sync1;
            m_sync1 = raw;
            for (int c = 0; c < N_BTN; c++) begin
                samp_q[c].push_back(d[c]);
                if (samp_q[c].size() > DEB) void'(samp_q[c].pop_front());
                all_diff = (samp_q[c].size() == DEB);
                foreach (samp_q[c][k]) if (samp_q[c][k] == m_level[c]) all_diff = 0;
                if (all_diff) begin
                    if (m_level[c]) e_release[c] = 1'b1;
                    else begin
                        e_press[c] = 1'b1;
                        press_t[c] = t;
                    end
                    m_level[c] = ~m_level[c];
                end
                if (m_level[c]) begin
                    age = t - press_t[c];
                    e_long[c] = (age == LONGC);
                    e_held[c] = (age >= LONGC);
`ifdef BTN_AUTOREPEAT_EN
                    if (age > LONGC && ((age - LONGC) % REP) == 0) e_press[c] = 1'b1;
`endif
                end
            end
        end
        e_level = m_level;
    endtask

    task automatic checkValue(input string tag, input logic [N_BTN-1:0] obs,
                              input logic [N_BTN-1:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("[TB] FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp_v);
        end
    endtask

    task automatic checkOutput();
        checkValue("level",     btn_level,     e_level);
        checkValue("press",     btn_press,     e_press);
        checkValue("release",   btn_release,   e_release);
        checkValue("long",      btn_long,      e_long);
        checkValue("held_long", btn_held_long, e_held);
    endtask

    // Hold the given inputs for a number of edges, checking after each one.
    task automatic applyStimulus(input logic [N_BTN-1:0] raw, input logic rst,
                                 input int cycles);
        btn_raw = raw;
        rst_n   = rst;
        repeat (cycles) begin
            @(posedge clk);
            modelEdge(raw, rst);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        logic [N_BTN-1:0] rnd_raw;
        for (int c = 0; c < N_BTN; c++) press_t[c] = 0;
        btn_raw = '0;
        rst_n   = 1'b0;

        // Reset with all buttons held, then release reset.
        applyStimulus(5'b11111, 1'b0, 3);
        checkValue("reset_level", btn_level, 5'b00000);
        applyStimulus(5'b11111, 1'b1, 5);
        checkValue("rst_lat_level_early", btn_level, 5'b00000);
        applyStimulus(5'b11111, 1'b1, 1);
        checkValue("rst_lat_level", btn_level, 5'b11111);
        checkValue("rst_lat_press", btn_press, 5'b11111);
        applyStimulus(5'b11111, 1'b1, 1);
        checkValue("rst_press_once", btn_press, 5'b00000);
        applyStimulus(5'b00000, 1'b1, 12);

        // Bounce on bit 0 then settle high.
        applyStimulus(5'b00001, 1'b1, 2);
        applyStimulus(5'b00000, 1'b1, 2);
        applyStimulus(5'b00001, 1'b1, 2);
        applyStimulus(5'b00000, 1'b1, 2);
        applyStimulus(5'b00001, 1'b1, 5);
        checkValue("bounce_level_early", btn_level, 5'b00000);
        applyStimulus(5'b00001, 1'b1, 1);
        checkValue("bounce_press", btn_press, 5'b00001);
        applyStimulus(5'b00000, 1'b1, 30);

        // Short press on bit 2.
        applyStimulus(5'b00100, 1'b1, 12);
        applyStimulus(5'b00000, 1'b1, 12);

        // Long press on bit 1.
        applyStimulus(5'b00010, 1'b1, 40);
        applyStimulus(5'b00000, 1'b1, 10);

        // Independent channels 3 and 4.
        applyStimulus(5'b11000, 1'b1, 10);
        applyStimulus(5'b01000, 1'b1, 30);
        applyStimulus(5'b00000, 1'b1, 10);

        // Long hold on bit 0 (auto-repeat when enabled).
        applyStimulus(5'b00001, 1'b1, 40);
        applyStimulus(5'b00000, 1'b1, 10);

        // Reset in the middle of a long hold, button still held.
        applyStimulus(5'b00010, 1'b1, 30);
        applyStimulus(5'b00010, 1'b0, 2);
        applyStimulus(5'b00010, 1'b1, 12);
        applyStimulus(5'b00000, 1'b1, 10);

        // Random phase: sparse bit flips with short random dwell times.
        rnd_raw = '0;
        for (int it = 0; it < 400; it++) begin
            rnd_raw = rnd_raw ^ N_BTN'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 59) == 0)
                applyStimulus(rnd_raw, 1'b0, $urandom_range(1, 3));
            else
                applyStimulus(rnd_raw, 1'b1, $urandom_range(1, 8));
        end
        applyStimulus(5'b00000, 1'b1, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Front-end conditioning stage for the five Basys3 push-buttons (btnC, btnL, btnR, btnU, btnD). It sits between the raw pins and every consumer in Top_Student: task modules, celebration detection and paint.
Per button it provides:
- a 2-FF synchroniser,
- a debouncer,
- press/release single-cycle pulses,
- long-press detection.
Consumers use the clean level or pulses instead of raw btn* inputs.

Parameters:
N_BTN, 5, number of independent button channels; bit order {btnD, btnU, btnR, btnL, btnC} = [4:0]
DEBOUNCE_CYCLES, 1000000, stable cycles required before the debounced level changes (10 ms @100 MHz); must be >= 2
LONG_CYCLES, 100000000, cycles a debounced press must last to count as long (1 s); must be > DEBOUNCE_CYCLES
REPEAT_CYCLES, 20000000, auto-repeat period (200 ms); used only with BTN_AUTOREPEAT_EN
CNT_W, 27, width of the debounce and hold counters; must hold max(LONG_CYCLES, REPEAT_CYCLES)

Ports:
clk  in  1  100 MHz system clock
rst_n  in  1  synchronous reset, active-low
btn_raw  in  N_BTN  asynchronous raw button pins
btn_level  out  N_BTN  debounced level, 1 = held
btn_press  out  N_BTN  1-cycle pulse on each debounced rising edge (and on each auto-repeat)
btn_release  out  N_BTN  1-cycle pulse on each debounced falling edge
btn_long  out  N_BTN  1-cycle pulse when a hold reaches LONG_CYCLES
btn_held_long  out  N_BTN  level; 1 from the btn_long pulse until release

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is synchronous and active-low. All state changes on posedge clk only.
- Reset values (rst_n=0 at a posedge): sync flops 0, counters 0, FSM IDLE, all outputs 0.
- Synchroniser: sync1 <= btn_raw; sync2 <= sync1.
- Debounce, per bit, each edge:
  - if sync2 == level: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: level <= sync2, cnt <= 0.
  - else cnt <= cnt+1.
  - Latency from stable raw change to the btn_level change is exactly DEBOUNCE_CYCLES+2 edges.
  - Any bounce back to the current level clears cnt.
- Pulses: btn_press and btn_release are registered and asserted in the same cycle btn_level changes. Each is high for exactly 1 cycle.
- Hold FSM, per bit, states IDLE, PRESSED, LONG:
  - IDLE -> PRESSED on debounced rise; hold_cnt <= 0.
  - PRESSED: hold_cnt increments each cycle.
    - When hold_cnt == LONG_CYCLES-1: go to LONG; btn_long pulses 1 cycle; btn_held_long <= 1.
    - Debounced fall returns to IDLE.
    - btn_long pulses exactly LONG_CYCLES edges after btn_press.
  - LONG: stay until debounced fall. Then go to IDLE, btn_release pulses and btn_held_long <= 0 in the same cycle. btn_long never re-fires within one hold.
  - Fall and LONG threshold in the same cycle: fall wins; no btn_long.
- Channels are fully independent; simultaneous presses produce simultaneous pulses.
- Reset mid-hold: all outputs drop to 0. If the button is still held, btn_level/btn_press re-assert DEBOUNCE_CYCLES+2 edges after rst_n returns high.
- Counters never wrap. The debounce counter is bounded by DEBOUNCE_CYCLES-1; the hold counter stops in LONG.

Optional Feature:
BTN_AUTOREPEAT_EN
- Defined: in LONG, rep_cnt counts and btn_press re-pulses every REPEAT_CYCLES edges. The first repeat comes REPEAT_CYCLES edges after btn_long. rep_cnt clears on release and on reset.
- Undefined: no rep_cnt logic; btn_press pulses only on debounced rising edges.

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5.
1. Reset: rst_n=0 for 3 cycles with btn_raw=5'b11111 -> all outputs 0. After rst_n=1, btn_level=5'b11111 and btn_press=5'b11111 for 1 cycle exactly 6 edges later.
2. Bounce: btn_raw[0] toggles 1,0,1,0 every 2 cycles, then stays 1 -> no btn_press during toggling. btn_press[0] pulses 6 edges after the final rise; btn_level[0]=1.
3. Short press: btn_raw[2] high for 12 cycles -> one btn_press[2] pulse, one btn_release[2] pulse 12 edges later, btn_long[2]=0 throughout.
4. Long press: btn_raw[1] high for 40 cycles -> btn_long[1] pulses 20 edges after btn_press[1]. btn_held_long[1]=1 until the btn_release[1] cycle. Without the macro, only one btn_press[1] pulse.
5. Independence: btn_raw[3] and btn_raw[4] rise in the same cycle; btn_raw[4] drops after 10 cycles -> simultaneous press pulses on bits 3 and 4. Bit 3's btn_long is unaffected by bit 4's release.
6. With BTN_AUTOREPEAT_EN: hold btn_raw[0] for 40 cycles -> btn_press[0] pulses at the initial press, then 5, 10, 15 ... edges after btn_long[0]. Repeats stop on the btn_release[0] cycle.
